mmio_timer_resp: RTL and testbench
==================================

Name: mmio_timer_resp

Overview:
- Memory-mapped bus responder on the CPU's MEM-stage data bus, alongside data memory, the existing peripherals and the UART unit.
- Provides a reloadable 32-bit interval timer with an interrupt request, plus a free-running cycle counter.
- Read data is combinational and zero when the block is not selected, so it can be OR-combined with the other responders' read data.

Parameters:
- BASE_ADDR, 32'h4000_0100, byte base address of the 32-byte register window (aligned to 32).
- RESET_TH, 32'h0000_0000, reset value of the TH reload register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- rd  input  1  bus read strobe (MEM stage).
- wr  input  1  bus write strobe (MEM stage).
- addr  input  32  byte address from the MEM-stage ALU result.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational; 0 unless rd is high and addr hits a mapped register.
- irqout  output  1  interrupt request, level.

Behaviour:
- Decode:
  - sel = (addr[31:5] == BASE_ADDR[31:5]); word index = addr[4:2]; addr[1:0] ignored.
  - 0: TH (RW).
  - 1: TL (RW).
  - 2: TCON (RW) — bit0 EN, bit1 IE, bit2 ST; bits 31:3 read 0, writes ignored.
  - 3: SYSTICK (RO).
  - 4: PRESC (RW, only with the optional feature).
  - Other indices read 0; writes to them are ignored.
- Reset (sync, high): TH=RESET_TH, TL=0, TCON=0, SYSTICK=0, prescale counter=0, PRESC=0. Outputs: rdata=0, irqout=0.
- SYSTICK: increments by 1 every cycle reset is low; wraps 32'hFFFF_FFFF -> 0; CPU writes ignored.
- tick: 1 every cycle when the feature is absent; see Optional Feature otherwise.
- Timer, on a cycle with EN=1 and tick=1:
  - if TL == 32'hFFFF_FFFF, then TL <= TH and ST <= 1 when IE=1;
  - else TL <= TL+1.
  - With EN=0, TL holds.
- Writes take effect at the clock edge when wr && sel.
  - A CPU write to TL/TH has priority over the timer update in the same cycle; the written value is loaded and no increment or reload happens that cycle.
  - A write to TCON loads EN, IE, ST from wdata[2:0].
  - An overflow setting ST in the same cycle has priority over a write of ST=0, so the interrupt is not lost.
  - Software clears ST by writing 0 to bit2.
- Reads with rd && sel: rdata shows the current register value. If rd and wr are both high, rdata shows the pre-write value.
- irqout = IE & ST, registered-state derived (no combinational path from bus inputs).
- Clearing IE drops irqout in the next cycle; ST is retained.
- Reset asserted mid-count returns all state to reset values at that edge; a pending irq is dropped.
- Latency:
  - read: 0 cycles (combinational);
  - write-to-readback: 1 cycle;
  - overflow-to-irqout: 1 cycle after the edge where TL == FFFF_FFFF is consumed.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - PRESC register at index 4, 16 bits used; bits 31:16 read 0.
  - An internal 16-bit prescale counter runs while EN=1; tick=1 when the counter equals PRESC, and the counter then resets to 0.
  - PRESC=0 gives a tick every cycle. A write to PRESC also clears the prescale counter.
  - The prescale counter holds when EN=0.
- Undefined: index 4 reads 0, writes are ignored, tick=1 every cycle.

Test Plan:
- Reset then read all indices -> TH=RESET_TH, TL=0, TCON=0, SYSTICK reads 0 on the first cycle after reset deassert and increments by 1 per cycle afterwards; irqout=0.
- Write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3 -> TL reads FFFF_FFFF after 1 tick, then FFFF_FFF0. ST=1 and irqout=1 one cycle after the reload.
- irqout high, then write TCON=3 (ST=0) -> irqout=0 next cycle; a write coinciding with an overflow edge leaves ST=1.
- Address BASE_ADDR+32 with rd=1 -> rdata=0. Address BASE_ADDR+0x14 (index 5) with wr=1 -> no state changes. rd=0 at a mapped address -> rdata=0.
- Write TL=5 in the same cycle as an enabled tick -> TL reads 5, then 6.
- With TIMER_PRESCALE_EN: PRESC=3, TCON=1, TL=0 -> TL advances by 1 every 4 cycles, reading 2 after 8 enabled cycles. Without the macro, index 4 reads 0.

Source files
------------

// File: rtl/mmio_timer_resp.sv
// rtl/mmio_timer_resp.sv - MMIO interval timer with irq and free-running SYSTICK
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module mmio_timer_resp #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0100,
   parameter logic [31:0] RESET_TH  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        st_q, st_d;
   logic [31:0] systick_q;
   logic        sel;
   logic [2:0]  idx;
   logic        wr_sel;
   logic        tick;
   logic        ovf_set;
   logic        unused_addr_bits;

   assign sel              = (addr[31:5] == BASE_ADDR[31:5]);
   assign idx              = addr[4:2];
   assign wr_sel           = wr && sel;
   assign unused_addr_bits = &{1'b0, addr[1:0]};

`ifdef TIMER_PRESCALE_EN
   logic [15:0] presc_q, presc_d;
   logic [15:0] pcnt_q, pcnt_d;

   assign tick = (pcnt_q == presc_q);

   always_comb begin
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      if (en_q) begin
         pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      end
      if (wr_sel && idx == 3'd4) begin
         presc_d = wdata[15:0];
         pcnt_d  = 16'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= 16'd0;
         pcnt_q  <= 16'd0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // A bus write to TH or TL suppresses the timer update for that cycle entirely.
   always_comb begin
      th_d    = th_q;
      tl_d    = tl_q;
      en_d    = en_q;
      ie_d    = ie_q;
      st_d    = st_q;
      ovf_set = 1'b0;
      if (wr_sel && (idx == 3'd0 || idx == 3'd1)) begin
         if (idx == 3'd0) th_d = wdata;
         else             tl_d = wdata;
      end else if (en_q && tick) begin
         if (tl_q == 32'hFFFF_FFFF) begin
            tl_d    = th_q;
            ovf_set = ie_q;
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end
      if (wr_sel && idx == 3'd2) begin
         en_d = wdata[0];
         ie_d = wdata[1];
         st_d = wdata[2];
      end
      if (ovf_set) st_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         th_q      <= RESET_TH;
         tl_q      <= 32'd0;
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         st_q      <= 1'b0;
         systick_q <= 32'd0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         en_q      <= en_d;
         ie_q      <= ie_d;
         st_q      <= st_d;
         systick_q <= systick_q + 32'd1;
      end
   end

   assign irqout = ie_q & st_q;

   always_comb begin
      rdata = 32'd0;
      if (rd && sel && !reset) begin
         case (idx)
            3'd0:    rdata = th_q;
            3'd1:    rdata = tl_q;
            3'd2:    rdata = {29'd0, st_q, ie_q, en_q};
            3'd3:    rdata = systick_q;
`ifdef TIMER_PRESCALE_EN
            3'd4:    rdata = {16'd0, presc_q};
`endif
            default: rdata = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer_resp.sv
// tb/tb_mmio_timer_resp.sv - directed self-checking bench for mmio_timer_resp
module tb_mmio_timer_resp;

   localparam logic [31:0] BASE = 32'h4000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irqout;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_tick = 32'd0;

   mmio_timer_resp #(.BASE_ADDR(BASE), .RESET_TH(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(rdata), .irqout(irqout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) exp_tick <= 32'd0;
      else       exp_tick <= exp_tick + 32'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd_raw(input logic [31:0] a, input logic [31:0] exp, input string tag);
      rd = 1'b1;
      addr = a;
      #1;
      check(tag, rdata, exp);
      rd = 1'b0;
   endtask

   task automatic rd_reg(input int idx, input logic [31:0] exp, input string tag);
      rd_raw(BASE + 32'(idx * 4), exp, tag);
   endtask

   task automatic wr_raw(input logic [31:0] a, input logic [31:0] d);
      wr = 1'b1;
      addr = a;
      wdata = d;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic wr_reg(input int idx, input logic [31:0] d);
      wr_raw(BASE + 32'(idx * 4), d);
   endtask

   task automatic irq_chk(input logic exp, input string tag);
      #1;
      check(tag, {31'd0, irqout}, {31'd0, exp});
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      // reset state
      rd_reg(0, 32'h0, "rst_th");
      rd_reg(1, 32'h0, "rst_tl");
      rd_reg(2, 32'h0, "rst_tcon");
      rd_reg(3, 32'h0, "rst_systick0");
      rd_reg(4, 32'h0, "rst_idx4");
      irq_chk(1'b0, "rst_irq");
      @(negedge clk);
      rd_reg(3, 32'd1, "systick1");
      @(negedge clk);
      rd_reg(3, 32'd2, "systick2");

      // reload / overflow
      wr_reg(0, 32'hFFFF_FFF0);
      wr_reg(1, 32'hFFFF_FFFE);
      wr_reg(2, 32'd3);
      rd_reg(1, 32'hFFFF_FFFE, "tl_pre");
      irq_chk(1'b0, "irq_pre");
      @(negedge clk);
      rd_reg(1, 32'hFFFF_FFFF, "tl_ffff");
      irq_chk(1'b0, "irq_ffff");
      @(negedge clk);
      rd_reg(1, 32'hFFFF_FFF0, "tl_reload");
      rd_reg(2, 32'd7, "tcon_st");
      irq_chk(1'b1, "irq_ovf");
      @(negedge clk);
      rd_reg(1, 32'hFFFF_FFF1, "tl_after");

      // clear ST
      wr_reg(2, 32'd3);
      irq_chk(1'b0, "irq_clr");
      rd_reg(2, 32'd3, "tcon_clr");
      rd_reg(1, 32'hFFFF_FFF2, "tl_clr");

      // clear of ST racing an overflow
      wr_reg(1, 32'hFFFF_FFFE);
      rd_reg(1, 32'hFFFF_FFFE, "tl_wr_pri");
      @(negedge clk);
      rd_reg(1, 32'hFFFF_FFFF, "tl_race_pre");
      wr_reg(2, 32'd3);
      irq_chk(1'b1, "irq_race");
      rd_reg(2, 32'd7, "tcon_race");
      rd_reg(1, 32'hFFFF_FFF0, "tl_race");

      // clearing IE drops irq, ST retained
      wr_reg(2, 32'd5);
      irq_chk(1'b0, "irq_ie0");
      rd_reg(2, 32'd5, "tcon_ie0");
      rd_reg(1, 32'hFFFF_FFF1, "tl_ie0");

      // decode boundaries
      rd_raw(BASE + 32'd32, 32'h0, "rd_outside");
      rd_raw(BASE + 32'h1C, 32'h0, "rd_idx7");
      addr = BASE + 32'd4;
      rd = 1'b0;
      #1;
      check("rd_low", rdata, 32'h0);
      wr_raw(BASE + 32'h14, 32'hFFFF_FFFF);
      rd_reg(0, 32'hFFFF_FFF0, "idx5_th");
      rd_reg(2, 32'd5, "idx5_tcon");
      rd_reg(1, 32'hFFFF_FFF2, "idx5_tl");
      rd_raw(BASE + 32'd6, 32'hFFFF_FFF2, "tl_lowbits");

      // TL write beats enabled tick
      wr_reg(1, 32'd5);
      rd_reg(1, 32'd5, "tl_wr5");
      @(negedge clk);
      rd_reg(1, 32'd6, "tl_wr6");

      // SYSTICK tracks cycles and ignores writes
      wr_reg(3, 32'h1234_5678);
      rd_reg(3, exp_tick, "systick_wr");
      @(negedge clk);
      rd_reg(3, exp_tick, "systick_run");

      // reset mid-count with irq pending
      wr_reg(2, 32'd7);
      irq_chk(1'b1, "irq_pend");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      irq_chk(1'b0, "irq_rst");
      rd_reg(0, 32'h0, "th_rst2");
      rd_reg(1, 32'h0, "tl_rst2");
      rd_reg(2, 32'h0, "tcon_rst2");
      rd_reg(3, 32'h0, "systick_rst2");

`ifdef TIMER_PRESCALE_EN
      wr_reg(4, 32'hFFFF_0003);
      rd_reg(4, 32'h0000_0003, "presc_rd");
      wr_reg(1, 32'd0);
      wr_reg(2, 32'd1);
      rd_reg(1, 32'd0, "presc_tl0");
      repeat (3) @(negedge clk);
      rd_reg(1, 32'd0, "presc_tl3");
      @(negedge clk);
      rd_reg(1, 32'd1, "presc_tl4");
      repeat (4) @(negedge clk);
      rd_reg(1, 32'd2, "presc_tl8");
`else
      wr_reg(4, 32'd3);
      rd_reg(4, 32'h0, "idx4_zero");
      wr_reg(2, 32'd1);
      repeat (3) @(negedge clk);
      rd_reg(1, 32'd3, "notick_pre_tl");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
